// File: rtl/memory_port_arbiter_if.sv
// Core-side memory bus shared by the fetch and load/store ports.
// master: requesters plus memory controller (environment); slave: the arbiter.
interface memory_port_arbiter_if;
  logic [31:0] fetchAddress;
  logic        fetchReadEnable;
  logic [31:0] fetchDataRead;
  logic        fetchBusy;

  logic [31:0] dataAddress;
  logic [3:0]  dataByteSelect;
  logic        dataWriteEnable;
  logic        dataReadEnable;
  logic [31:0] dataDataWrite;
  logic [31:0] dataDataRead;
  logic        dataBusy;

  logic [31:0] coreAddress;
  logic [3:0]  coreByteSelect;
  logic        coreWriteEnable;
  logic        coreReadEnable;
  logic [31:0] coreDataWrite;
  logic [31:0] coreDataRead;
  logic        coreBusy;

  modport master (
    output fetchAddress, fetchReadEnable,
    input  fetchDataRead, fetchBusy,
    output dataAddress, dataByteSelect, dataWriteEnable, dataReadEnable, dataDataWrite,
    input  dataDataRead, dataBusy,
    input  coreAddress, coreByteSelect, coreWriteEnable, coreReadEnable, coreDataWrite,
    output coreDataRead, coreBusy
  );

  modport slave (
    input  fetchAddress, fetchReadEnable,
    output fetchDataRead, fetchBusy,
    input  dataAddress, dataByteSelect, dataWriteEnable, dataReadEnable, dataDataWrite,
    output dataDataRead, dataBusy,
    output coreAddress, coreByteSelect, coreWriteEnable, coreReadEnable, coreDataWrite,
    input  coreDataRead, coreBusy
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Fetch/data arbiter for the single core memory bus. Ownership parks on the last
// owner and only changes on transaction boundaries.
module memory_port_arbiter (
  input logic                  clk,
  input logic                  rst,
  memory_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t state;
  state_t next_state;

  logic fetch_req;
  logic data_req;

  assign fetch_req = bus.fetchReadEnable;
  assign data_req  = bus.dataReadEnable | bus.dataWriteEnable;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block is given a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state          = state;
    bus.coreAddress     = '0;
    bus.coreByteSelect  = '0;
    bus.coreWriteEnable = 1'b0;
    bus.coreReadEnable  = 1'b0;
    bus.coreDataWrite   = '0;
    bus.fetchDataRead   = '1;
    bus.dataDataRead    = '1;

    unique case (state)
      IDLE: begin
        if (fetch_req)     next_state = FETCH;
        else if (data_req) next_state = DATA;
      end

      FETCH: begin
        bus.coreAddress    = bus.fetchAddress;
        bus.coreByteSelect = 4'b1111;
        bus.coreReadEnable = bus.fetchReadEnable;
        bus.fetchDataRead  = bus.coreDataRead;
        // An in-flight fetch holds the bus; otherwise hand off or stay parked.
        if (!(fetch_req && bus.coreBusy) && data_req) next_state = DATA;
      end

      DATA: begin
        bus.coreAddress     = bus.dataAddress;
        bus.coreByteSelect  = bus.dataByteSelect;
        bus.coreWriteEnable = bus.dataWriteEnable;
        bus.coreReadEnable  = bus.dataReadEnable;
        bus.coreDataWrite   = bus.dataDataWrite;
        bus.dataDataRead    = bus.coreDataRead;
        if (!(data_req && bus.coreBusy) && fetch_req) next_state = FETCH;
      end

      default: next_state = IDLE;
    endcase
  end

  assign bus.fetchBusy = fetch_req & ~((state == FETCH) & ~bus.coreBusy);
  assign bus.dataBusy  = data_req  & ~((state == DATA)  & ~bus.coreBusy);

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Two-port arbiter that shares the single core-side memory bus between the ExperiarCore instruction fetch port and its load/store data port. It sits between the core pipeline and the memory controller, driving the controller's core interface: address, byte select, enables, write data, read data and busy. Ownership is tracked by a registered state machine that parks on the last owner. It hands off only on transaction boundaries, so an in-flight local-memory or Wishbone access is never interrupted.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetchAddress  in  32  instruction fetch address.
- fetchReadEnable  in  1  fetch request; held with its address until fetchBusy low.
- fetchDataRead  out  32  read data to fetch port.
- fetchBusy  out  1  fetch transaction not yet complete.
- dataAddress  in  32  load/store address.
- dataByteSelect  in  4  load/store byte lanes.
- dataWriteEnable  in  1  store request.
- dataReadEnable  in  1  load request.
- dataDataWrite  in  32  store data.
- dataDataRead  out  32  read data to data port.
- dataBusy  out  1  data transaction not yet complete.
- coreAddress  out  32  to memory controller.
- coreByteSelect  out  4  to memory controller.
- coreWriteEnable  out  1  to memory controller.
- coreReadEnable  out  1  to memory controller.
- coreDataWrite  out  32  to memory controller.
- coreDataRead  in  32  from memory controller.
- coreBusy  in  1  from memory controller; combinational with the request.

## Operation
- Request signals:
  - fetchReq = fetchReadEnable.
  - dataReq = dataReadEnable | dataWriteEnable.
- A transaction completes in any cycle where the owner's request is high and coreBusy is low.
- States: IDLE, FETCH, DATA. Reset → IDLE.
- IDLE:
  - fetchReq → FETCH, otherwise dataReq → DATA, otherwise stay.
  - Fetch wins a tie.
- FETCH: stay while fetch is requesting and not complete. Otherwise:
  - dataReq → DATA.
  - If dataReq is low, park in FETCH.
- DATA: symmetric to FETCH.
  - On completion or when dataReq is low: fetchReq → FETCH, else park in DATA.
- Net effect:
  - Alternating requesters are served round-robin per transaction.
  - A lone requester streams back-to-back while parked.
- Bus outputs in IDLE: all zero.
- Bus outputs in FETCH:
  - coreAddress = fetchAddress, coreByteSelect = 4'b1111, coreReadEnable = fetchReadEnable.
  - coreWriteEnable = 0, coreDataWrite = 0.
- Bus outputs in DATA: all data-port fields are forwarded unchanged.
- fetchBusy = fetchReq & !(state==FETCH & !coreBusy). dataBusy is the same expression with DATA.
- Read data:
  - The owner gets coreDataRead.
  - A non-owner gets ~32'b0.
  - In IDLE both ports get ~32'b0.
- Requesters must hold their request until their busy goes low. If the owner drops its request while coreBusy is high, the arbiter treats the transaction as abandoned and may switch owner. The downstream result is undefined.

## Timing
- Reset values, with no requests present:
  - state IDLE; all core* outputs 0.
  - fetchBusy = dataBusy = 0; fetchDataRead = dataDataRead = ~32'b0.
- Reset mid-transaction: state returns to IDLE at the next edge and the bus enables drop in the following cycle. The requester's busy stays high if its request persists.
- Request from IDLE:
  - Cycle 0: request is seen, the requester's busy is high, the bus is idle.
  - Cycle 1: the request is forwarded.
  - Minimum latency is 2 cycles.
- Request from a port that already owns the bus (parked): forwarded in the same cycle, zero arbitration latency.
- Handoff: when a transaction completes in cycle N and the other port is waiting, the other port is forwarded in cycle N+1.
- Non-owner request arriving while the owner is idle-parked: the grant switches at the next edge, 1 cycle of latency.
- Ownership never changes in a cycle where the owner's request is high and coreBusy is high.

## Test plan
- **Reset**: rst=1 for 2 cycles with requests held → all core* = 0 and fetchDataRead = ~32'b0. After release, with fetchReadEnable=1, fetchAddress=0x00000100 and coreBusy=0: coreReadEnable=1 in cycle 1 and fetchBusy falls in cycle 1.
- **Streaming fetch**: fetch-only requests to 0x100, 0x104, 0x108 with coreBusy=0 → after the first grant, one completion per cycle and coreByteSelect=4'b1111 throughout.
- **Simultaneous requests**: from IDLE, fetch and a load to 0x10000000 with byte select 4'b0011 are raised together → fetch is served first. The load is forwarded the cycle after fetch completes, with coreByteSelect=4'b0011.
- **No preemption under busy**: data owns the bus and coreBusy is held high for 5 cycles while fetch requests → coreAddress stays dataAddress for all 5 cycles. Fetch is forwarded the cycle after coreBusy falls.
- **Store forwarding**: a store of 0xDEADBEEF to 0x00000040 while parked on DATA → coreWriteEnable=1 and coreDataWrite=0xDEADBEEF in the same cycle. fetchDataRead = ~32'b0 during the store.
- **Reset mid-transaction**: assert rst while DATA is busy → the next cycle shows state IDLE and coreWriteEnable=0 and coreReadEnable=0. dataBusy stays high while dataReq is held.
